op_feeder: RTL
==============

OP_FEEDER -- requirements
Module: op_feeder

Interface
REQ-001 Parameter: WIDTH, 4, operand width in bits; one serial input word carries one operand.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_data  input  WIDTH  serial operand word: first word of a pair is operand a, second is operand b.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  block accepts in_data this cycle; a word transfers when in_valid && in_ready.
REQ-007 a  output  WIDTH  head-pair operand a, driven directly to the downstream combinational a/b->o stage.
REQ-008 b  output  WIDTH  head-pair operand b, driven directly to the downstream stage.
REQ-009 ab_valid  output  1  a/b hold a complete, unconsumed pair.
REQ-010 ab_ready  input  1  downstream consumes the pair; a pair is popped when ab_valid && ab_ready.
REQ-011 pair_cnt  output  8  popped-pair count; present only with OP_FEEDER_CNT_EN.

Function
REQ-012 Loader FSM states: LOAD_A and LOAD_B.
REQ-013 LOAD_A: an accepted word goes to staging register stg_a, then LOAD_B.
REQ-014 LOAD_B: an accepted word is pushed as pair {stg_a, word} into the pair FIFO, then LOAD_A.
REQ-015 No accepted word: FSM holds its state.
REQ-016 Pair FIFO: depth 2, first in first out, occupancy count 0..2.
REQ-017 in_ready = (state==LOAD_A) || (count<2), from registered state only, with no combinational path from ab_ready.
REQ-018 ab_valid = (count!=0); a/b = head entry; head value is stable while ab_valid && !ab_ready.
REQ-019 count=0: a/b hold the last popped pair (0 after reset), with ab_valid low.
REQ-020 Latency: a pair is visible on a/b with ab_valid high the cycle after its b word is accepted into an empty FIFO.
REQ-021 Simultaneous push and pop: count is unchanged and order is preserved; with count=1, the pushed pair becomes head on the next cycle.
REQ-022 count=2 in LOAD_B: in_ready is low, even if a pop occurs that cycle; input resumes the following cycle.
REQ-023 count=2 in LOAD_A: word a is still accepted into stg_a.
REQ-024 FIFO read/write pointers are 1 bit wide and wrap 1->0.
REQ-025 in_data while !in_valid is ignored; ab_ready while !ab_valid has no effect.

Reset
REQ-026 rst high at a clock edge: state=LOAD_A, count=0, pointers=0, stg_a=0, FIFO entries=0, pair_cnt=0.
REQ-027 Reset values: ab_valid=0, a=0, b=0, in_ready=1 the cycle after reset.
REQ-028 Reset mid-pair: a pending a word is discarded and the FIFO is emptied, with no partial pair emitted.
REQ-029 Reset overrides any simultaneous transfer on either interface.

Configuration
REQ-030 Macro OP_FEEDER_CNT_EN defined: pair_cnt increments by 1 on every pop, wraps 255->0, and is reset to 0.
REQ-031 Macro OP_FEEDER_CNT_EN undefined: pair_cnt port and counter logic are absent, with all other behaviour identical.

Structure
REQ-032 Package op_feeder_pkg holds the loader state enum (LOAD_A, LOAD_B), the default width constant 4 and the FIFO depth constant 2.
REQ-033 Sub-module pair_fifo (2-entry, 2*WIDTH data, push/pop/count) is instantiated once; FSM and staging register stay in op_feeder.

Verification
REQ-034 Reset, then in_data 0x0,0x3 with ab_ready=1 -> one cycle later a=0x0, b=0x3, ab_valid=1; popped next edge; ab_valid=0 after.
REQ-035 ab_ready=0; words 0x3,0x3,0xF,0x3,0xF,0xF -> count=2 after the fourth word; the fifth word (0xF) accepted, sixth stalled (in_ready=0); a/b stay 0x3/0x3.
REQ-036 REQ-035 state, then ab_ready=1 for 3 cycles -> pairs (3,3), (F,3), (F,F) emitted in order, including the simultaneous push/pop.
REQ-037 Word 0x1 accepted, then rst pulsed, then words 0x1,0x1 -> exactly one pair (1,1) emitted, with no stale a word.
REQ-038 With OP_FEEDER_CNT_EN, 257 pairs streamed with ab_ready=1 -> pair_cnt=1; without the macro, the same bench minus pair_cnt passes.
REQ-039 Random in_valid/ab_ready, 1000 pairs -> output sequence equals input pairs, with no drops or duplicates.

Source files
------------

// File: rtl/op_feeder_pkg.sv
// Shared types and constants for the op_feeder operand loader.
package op_feeder_pkg;

  localparam int          DEF_WIDTH  = 4;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic {
    LOAD_A = 1'b0,
    LOAD_B = 1'b1
  } load_state_t;

endpackage

// File: rtl/pair_fifo.sv
// Two-entry operand-pair FIFO with 1-bit wrapping pointers.
// While empty, head keeps presenting the most recently popped entry.
module pair_fifo
  import op_feeder_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Guard against overflow/underflow so the count can never leave 0..2.
  always_comb begin
    pop_ok  = pop && (count != 2'd0);
    push_ok = push && (count != 2'(FIFO_DEPTH));
  end

  // Storage, pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // When empty, the slot behind rd_ptr is the last popped entry; a push into
  // an empty FIFO writes the rd_ptr slot, so that value stays intact.
  always_comb begin
    head = (count != 2'd0) ? mem[rd_ptr] : mem[~rd_ptr];
  end

endmodule

// File: rtl/op_feeder.sv
// Serial operand loader: pairs consecutive words (a then b) and queues the
// pairs in a 2-entry FIFO feeding a downstream a/b stage.
// Optional popped-pair counter port enabled by macro OP_FEEDER_CNT_EN.
module op_feeder
  import op_feeder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             ab_valid,
  input  logic             ab_ready
`ifdef OP_FEEDER_CNT_EN
  ,
  output logic [7:0]       pair_cnt
`endif
);

  load_state_t        state;
  load_state_t        state_nx;
  logic [WIDTH-1:0]   stg_a;
  logic               accept;
  logic               push;
  logic               pop;
  logic [2*WIDTH-1:0] head;
  logic [1:0]         count;

  // Handshakes; in_ready uses registered state/count only (no ab_ready path).
  always_comb begin
    in_ready = (state == LOAD_A) || (count != 2'(FIFO_DEPTH));
    accept   = in_valid && in_ready;
    push     = accept && (state == LOAD_B);
    pop      = ab_valid && ab_ready;
    ab_valid = (count != 2'd0);
    a        = head[2*WIDTH-1:WIDTH];
    b        = head[WIDTH-1:0];
  end

  // Loader state register.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_A;
    else     state <= state_nx;
  end

  // Loader next state: alternate on each accepted word, otherwise hold.
  always_comb begin
    state_nx = state;
    if (accept) begin
      case (state)
        LOAD_A:  state_nx = LOAD_B;
        LOAD_B:  state_nx = LOAD_A;
        default: state_nx = LOAD_A;
      endcase
    end
  end

  // Staging register for operand a.
  always_ff @(posedge clk) begin
    if (rst)                           stg_a <= '0;
    else if (accept && state == LOAD_A) stg_a <= in_data;
  end

  pair_fifo #(
    .DW(2 * WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({stg_a, in_data}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

`ifdef OP_FEEDER_CNT_EN
  // Popped-pair counter, wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (rst)      pair_cnt <= '0;
    else if (pop) pair_cnt <= pair_cnt + 8'd1;
  end
`endif

endmodule
